// File: rtl/alt_vipitc131_frame_read_cmd_gen_pkg.sv
// Shared types and helpers for the frame-reader command generator.
// The state encoding and burst sizing are common to the top and its bench.
package alt_vipitc131_frame_read_cmd_gen_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CMD    = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;

  function automatic int unsigned bytes_per_word(input int unsigned data_width);
    return data_width / 8;
  endfunction

  function automatic int unsigned min_burst(input int unsigned max_burst,
                                            input int unsigned words_left);
    return (words_left < max_burst) ? words_left : max_burst;
  endfunction

endpackage

// File: rtl/alt_vipitc131_frame_read_out_buffer.sv
// Two-entry FIFO holding {data, eol, eof} between the read port and the pixel stream.
// Writes and pops may coincide at any nonzero occupancy.
module alt_vipitc131_frame_read_out_buffer #(
  parameter int WIDTH = 34
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [1:0]       level
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             pop;

  assign pop      = rd_valid && rd_ready;
  assign rd_valid = (count != 2'd0);
  assign rd_data  = mem[rd_ptr];
  assign level    = count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(wr_en) - 2'(pop);
    end
  end

endmodule

// File: rtl/alt_vipitc131_frame_read_cmd_gen.sv
// Walks one frame in memory line by line, issues bursting read commands and
// streams the returned words out with end-of-line/end-of-frame markers.
//
// state  | meaning
// IDLE   | waiting for go; config latched on go
// CMD    | issuing bursts for the current line, throttled by outstanding words
// DRAIN  | all commands issued, waiting for the eof word to leave the stream
// FINISH | frame complete; done pulses on the following cycle
module alt_vipitc131_frame_read_cmd_gen
  import alt_vipitc131_frame_read_cmd_gen_pkg::*;
#(
  parameter int ADDR_WIDTH                     = 32,
  parameter int DATA_WIDTH                     = 32,
  parameter int MAX_BURST_LENGTH_REQUIREDWIDTH = 11,
  parameter int MAX_BURST                      = 32,
  parameter int WORDS_WIDTH                    = 12,
  parameter int LINES_WIDTH                    = 12,
  parameter int MAX_OUTSTANDING                = 64
) (
  input  logic                                      clock,
  input  logic                                      reset_n,
  input  logic                                      go,
  input  logic [ADDR_WIDTH-1:0]                     base_addr,
  input  logic [ADDR_WIDTH-1:0]                     stride,
  input  logic [WORDS_WIDTH-1:0]                    line_words,
  input  logic [LINES_WIDTH-1:0]                    lines,
  output logic                                      busy,
  output logic                                      done,
  output logic [ADDR_WIDTH-1:0]                     addr,
  output logic                                      command,
  output logic                                      is_burst,
  output logic                                      is_write_not_read,
  output logic [MAX_BURST_LENGTH_REQUIREDWIDTH-1:0] burst_length,
  output logic                                      read,
  input  logic [DATA_WIDTH-1:0]                     readdata,
  input  logic                                      stall,
  output logic [DATA_WIDTH-1:0]                     dout_data,
  output logic                                      dout_valid,
  input  logic                                      dout_ready,
  output logic                                      dout_eol,
  output logic                                      dout_eof
);

  localparam int unsigned BYTES_PER_WORD = bytes_per_word(DATA_WIDTH);
  localparam int PEND_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int BL_W   = MAX_BURST_LENGTH_REQUIREDWIDTH;

  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0]  line_addr;
  logic [ADDR_WIDTH-1:0]  cur_addr;
  logic [ADDR_WIDTH-1:0]  cfg_stride;
  logic [ADDR_WIDTH-1:0]  burst_bytes;
  logic [WORDS_WIDTH-1:0] cfg_line_words;
  logic [WORDS_WIDTH-1:0] words_left;
  logic [WORDS_WIDTH-1:0] rd_word_cnt;
  logic [LINES_WIDTH-1:0] cfg_lines;
  logic [LINES_WIDTH-1:0] lines_left;
  logic [LINES_WIDTH-1:0] rd_line_cnt;
  logic [PEND_W-1:0]      pending;
  logic [PEND_W-1:0]      pend_add;
  logic [PEND_W-1:0]      pend_sub;
  logic [BL_W-1:0]        burst_len;
  logic [1:0]             buf_level;
  logic                   go_acc;
  logic                   cmd_acc;
  logic                   rd_acc;
  logic                   rd_inflight;
  logic                   last_burst;
  logic                   done_r;
  logic                   tag_eol;
  logic                   tag_eof;
  logic                   head_eol;
  logic                   head_eof;

  assign burst_len   = BL_W'(min_burst(MAX_BURST, 32'(words_left)));
  assign burst_bytes = ADDR_WIDTH'(burst_len) * ADDR_WIDTH'(BYTES_PER_WORD);
  assign last_burst  = (words_left == WORDS_WIDTH'(burst_len));

  // Once raised, command cannot drop while stalled: pending only falls without an accept.
  assign command = (state == CMD) &&
                   (32'(pending) + 32'(burst_len) <= 32'(MAX_OUTSTANDING));
  assign addr              = cur_addr;
  assign burst_length      = (state == CMD) ? burst_len : '0;
  assign is_burst          = 1'b1;
  assign is_write_not_read = 1'b0;

  assign go_acc  = (state == IDLE) && go;
  assign cmd_acc = command && !stall;
  assign rd_acc  = read && !stall;

  // A word already in flight still needs a slot, so it counts against the buffer.
  assign read = (pending != '0) && (({1'b0, buf_level} + {2'b00, rd_inflight}) < 3'd2);

  assign pend_add = cmd_acc ? PEND_W'(burst_len) : '0;
  assign pend_sub = rd_acc ? PEND_W'(1) : '0;

  assign busy = (state != IDLE) || done_r;
  assign done = done_r;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (go) begin
          state_nxt = ((line_words == '0) || (lines == '0)) ? FINISH : CMD;
        end
      end
      CMD: begin
        if (cmd_acc && last_burst && (lines_left == LINES_WIDTH'(1))) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (dout_valid && dout_ready && dout_eof) begin
          state_nxt = FINISH;
        end
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cfg_stride     <= '0;
      cfg_line_words <= '0;
      cfg_lines      <= '0;
      line_addr      <= '0;
      cur_addr       <= '0;
      words_left     <= '0;
      lines_left     <= '0;
      pending        <= '0;
      rd_inflight    <= 1'b0;
      done_r         <= 1'b0;
    end else begin
      if (go_acc) begin
        cfg_stride     <= stride;
        cfg_line_words <= line_words;
        cfg_lines      <= lines;
        line_addr      <= base_addr;
        cur_addr       <= base_addr;
        words_left     <= line_words;
        lines_left     <= lines;
      end else if (cmd_acc) begin
        if (last_burst) begin
          line_addr  <= line_addr + cfg_stride;
          cur_addr   <= line_addr + cfg_stride;
          words_left <= cfg_line_words;
          lines_left <= lines_left - LINES_WIDTH'(1);
        end else begin
          cur_addr   <= cur_addr + burst_bytes;
          words_left <= words_left - WORDS_WIDTH'(burst_len);
        end
      end
      pending     <= pending + pend_add - pend_sub;
      rd_inflight <= rd_acc;
      done_r      <= (state == FINISH);
    end
  end

  // Markers are tagged when readdata lands, so they follow return order exactly.
  assign tag_eol = (rd_word_cnt == cfg_line_words - WORDS_WIDTH'(1));
  assign tag_eof = tag_eol && (rd_line_cnt == cfg_lines - LINES_WIDTH'(1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_word_cnt <= '0;
      rd_line_cnt <= '0;
    end else if (go_acc) begin
      rd_word_cnt <= '0;
      rd_line_cnt <= '0;
    end else if (rd_inflight) begin
      if (tag_eol) begin
        rd_word_cnt <= '0;
        rd_line_cnt <= tag_eof ? '0 : rd_line_cnt + LINES_WIDTH'(1);
      end else begin
        rd_word_cnt <= rd_word_cnt + WORDS_WIDTH'(1);
      end
    end
  end

  alt_vipitc131_frame_read_out_buffer #(
    .WIDTH(DATA_WIDTH + 2)
  ) u_out_buffer (
    .clock    (clock),
    .reset_n  (reset_n),
    .wr_en    (rd_inflight),
    .wr_data  ({readdata, tag_eol, tag_eof}),
    .rd_data  ({dout_data, head_eol, head_eof}),
    .rd_valid (dout_valid),
    .rd_ready (dout_ready),
    .level    (buf_level)
  );

  assign dout_eol = dout_valid && head_eol;
  assign dout_eof = dout_valid && head_eof;

endmodule

// File: doc/alt_vipitc131_frame_read_cmd_gen.md
Name: alt_vipitc131_frame_read_cmd_gen

Overview:
- Upstream driver of the Avalon-MM bursting master's user-algorithm interface in the frame-reader path.
- On a go pulse, walks one frame in memory: lines at base_addr + n*stride, each line split into read bursts of at most MAX_BURST words.
- Issues read commands, pulls the returned words with read, and emits them as a valid/ready pixel-word stream with end-of-line/end-of-frame markers.

Parameters:
- ADDR_WIDTH, 32, byte address width (matches master addr).
- DATA_WIDTH, 32, word width; BYTES_PER_WORD = DATA_WIDTH/8.
- MAX_BURST_LENGTH_REQUIREDWIDTH, 11, width of burst_length.
- MAX_BURST, 32, maximum words per command.
- WORDS_WIDTH, 12, width of line_words.
- LINES_WIDTH, 12, width of lines.
- MAX_OUTSTANDING, 64, maximum words commanded but not yet read; must be >= MAX_BURST.

Ports:
- clock  in  1  single clock for all logic.
- reset_n  in  1  asynchronous, active-low reset.
- go  in  1  start pulse; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  frame start byte address; latched on go.
- stride  in  ADDR_WIDTH  byte distance between line starts; latched on go.
- line_words  in  WORDS_WIDTH  words per line; latched on go.
- lines  in  LINES_WIDTH  lines per frame; latched on go.
- busy  out  1  high from accepted go until done.
- done  out  1  one-cycle pulse when the frame is complete.
- addr  out  ADDR_WIDTH  command address to master.
- command  out  1  command request.
- is_burst  out  1  constant 1.
- is_write_not_read  out  1  constant 0.
- burst_length  out  MAX_BURST_LENGTH_REQUIREDWIDTH  words in the command.
- read  out  1  read-data request.
- readdata  in  DATA_WIDTH  word from master.
- stall  in  1  master stall; while high, command and read are not accepted.
- dout_data  out  DATA_WIDTH  stream data.
- dout_valid  out  1  stream valid.
- dout_ready  in  1  stream ready.
- dout_eol  out  1  qualifies the last word of a line.
- dout_eof  out  1  qualifies the last word of the frame.

Behaviour:
- Reset (async, reset_n=0) clears to:
  - outputs: busy=0, done=0, command=0, read=0, dout_valid=0, dout_eol=0, dout_eof=0, addr=0, burst_length=0.
  - state: state=IDLE, all counters 0, output buffer empty.
  - Reset asserted mid-frame aborts the frame; no done is generated.
- Acceptance rules:
  - Command accepted = command && !stall.
  - Read accepted = read && !stall.
  - readdata for an accepted read is valid exactly one cycle later and is written into the output buffer that cycle.
- Command FSM:
  - IDLE: on go, latch config; line_addr=cur_addr=base_addr; busy=1.
    - If line_words==0 or lines==0: go to FINISH (no commands, no data).
    - Else go to CMD.
  - CMD: burst_length = min(MAX_BURST, words_left_in_line); command=1 only when pending + burst_length <= MAX_OUTSTANDING.
    - addr and burst_length are held stable while command=1 and stall=1.
    - On accept: cur_addr += burst_length*BYTES_PER_WORD; words_left_in_line -= burst_length.
    - When a line's last burst is accepted: line_addr += stride; cur_addr = new line_addr; words_left reloads.
    - After the last line's last burst, go to DRAIN.
  - DRAIN: wait until the last word has been transferred out (dout_valid && dout_ready && dout_eof), then go to FINISH.
  - FINISH: done=1 for one cycle, busy=0, return to IDLE.
  - go is ignored outside IDLE.
- Pending counter:
  - += burst_length on command accept; -= 1 on read accept; both in the same cycle apply net.
  - Never negative, never exceeds MAX_OUTSTANDING.
- Read side:
  - read=1 when pending>0 and (buffer occupancy + reads in flight) < 2.
  - Guarantees no overflow with dout_ready low.
- Output buffer:
  - 2-entry FIFO; dout_* driven from head.
  - Simultaneous write and pop allowed when occupancy is 1 or 2.
- Markers:
  - Read-side word and line counters are tagged on each readdata write.
  - eol is set at the last word of each line; eof at the last word of the last line.
  - Counters wrap to 0 at line and frame end.
- Address arithmetic is modulo 2^ADDR_WIDTH; wrap-around is not flagged.

Decomposition:
- Shared package holds:
  - state enum {IDLE, CMD, DRAIN, FINISH};
  - BYTES_PER_WORD;
  - the min-burst function.
- Sub-module alt_vipitc131_frame_read_out_buffer: 2-entry FIFO carrying {data, eol, eof}, with a valid/ready output and a write port.

Test Plan:
- base=0x1000, stride=0x100, line_words=40, lines=2, MAX_BURST=32, stall=0, dout_ready=1:
  - commands (0x1000,32), (0x1080,8), (0x1100,32), (0x1180,8);
  - 80 words out, eol on words 40 and 80, eof on 80 only, one done pulse.
- Same config with stall toggling 1/0 every 3 cycles: addr/burst_length stable while stalled; identical command sequence and data order.
- dout_ready=0 for 50 cycles mid-line:
  - at most 2 words buffered, read deasserted, pending <= 64;
  - no data lost or duplicated after release.
- line_words=0, lines=5: no command, no dout_valid; done one cycle after FINISH entry; busy high 2 cycles.
- Random go pulses while busy: ignored; frame output unchanged.
- reset_n low mid-DRAIN: all outputs 0 immediately; next go runs a clean full frame.
